// File: rtl/mult_pkg.sv
// Shared definitions for the iterative radix-4 multiplier: FSM encoding and
// the operand magnitude helper used at operand acceptance.
package mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Widest operand the magnitude helper supports; callers cast the result back down.
   localparam int MAX_W = 64;

   // Unsigned magnitude of a width-bit operand held zero-extended in value.
   // The result is taken modulo 2^width by the caller, so -2^(width-1)
   // maps to 2^(width-1).
   function automatic logic [MAX_W-1:0] abs_u(input logic [MAX_W-1:0] value,
                                              input int                width,
                                              input logic              signed_mode);
      logic [MAX_W-1:0] shifted;
      shifted = value >> (width - 1);
      if (signed_mode && shifted[0]) begin
         return -value;
      end
      return value;
   endfunction

endpackage

// File: rtl/radix4_pp_row.sv
// One radix-4 partial-product row: WIDTH-bit multiplicand times a 2-bit digit.
module radix4_pp_row #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_multiplicand,
   input  logic [1:0]       i_digit,
   output logic [WIDTH+1:0] o_row
);

   logic [WIDTH+1:0] w_m1;
   logic [WIDTH+1:0] w_m2;

   assign w_m1 = (WIDTH+2)'(i_multiplicand);
   assign w_m2 = w_m1 << 1;

   always_comb begin
      // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
      o_row = '0;
      case (i_digit)
         2'd0:    o_row = '0;
         2'd1:    o_row = w_m1;
         2'd2:    o_row = w_m2;
         default: o_row = w_m1 + w_m2;
      endcase
   end

endmodule

// File: rtl/seq_radix4_multiplier.sv
// Iterative WIDTH x WIDTH multiplier, two multiplier bits per cycle, with
// per-operation signed/unsigned mode and valid/ready on both sides.
module seq_radix4_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out
);

   localparam int CNT_W = $clog2(WIDTH/2) + 1;

   state_t               r_state;
   state_t               w_next_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_abs_a;
   logic [WIDTH-1:0]     r_b_sh;
   logic                 r_neg;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_out;

   logic                 w_accept;
   logic                 w_last;
   logic [WIDTH+1:0]     w_row;
   logic [2*WIDTH-1:0]   w_row_shifted;
   logic [2*WIDTH-1:0]   w_acc_next;

   assign w_accept      = in_valid & in_ready;
   assign w_last        = (r_cnt == CNT_W'(WIDTH/2 - 1));
   assign w_row_shifted = (2*WIDTH)'(w_row) << {r_cnt, 1'b0};
   assign w_acc_next    = r_acc + w_row_shifted;
   assign out           = r_out;

   // The multiplier register shifts right two bits per step, so the row
   // always consumes its low digit.
   radix4_pp_row #(.WIDTH(WIDTH)) u_row (
      .i_multiplicand (r_abs_a),
      .i_digit        (r_b_sh[1:0]),
      .o_row          (w_row)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)  w_next_state = ST_CALC;
         ST_CALC: if (w_last)    w_next_state = ST_DONE;
         ST_DONE: if (out_ready) w_next_state = ST_IDLE;
         default:                w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset too so a discarded operation leaves no residue;
      //       all sequential updates use <= so every register samples pre-edge values.
      if (!rst_n) begin
         r_cnt   <= '0;
         r_abs_a <= '0;
         r_b_sh  <= '0;
         r_neg   <= 1'b0;
         r_acc   <= '0;
         r_out   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_abs_a <= WIDTH'(abs_u(MAX_W'(a), WIDTH, signed_mode));
                  r_b_sh  <= WIDTH'(abs_u(MAX_W'(b), WIDTH, signed_mode));
                  r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end
            end
            ST_CALC: begin
               r_acc  <= w_acc_next;
               r_cnt  <= r_cnt + CNT_W'(1);
               r_b_sh <= r_b_sh >> 2;
               if (w_last) begin
                  r_out <= r_neg ? -w_acc_next : w_acc_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_radix4_multiplier.sv
// Self-checking bench: directed table at WIDTH=8, backpressure and reset
// corner cases, then randomized WIDTH=16 operations against an arithmetic model.
`timescale 1ns/1ps
module tb_seq_radix4_multiplier;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8;
   logic [7:0]  a8, b8;
   logic [15:0] out8;

   logic        in_valid16, in_ready16, mode16, out_valid16, out_ready16;
   logic [15:0] a16, b16;
   logic [31:0] out16;

   int n_checks = 0;
   int n_fail   = 0;

   seq_radix4_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .signed_mode(mode8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out(out8)
   );

   seq_radix4_multiplier #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .signed_mode(mode16),
      .out_valid(out_valid16), .out_ready(out_ready16), .out(out16)
   );

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        mode;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic get_in_ready(input int w);
      return (w == 8) ? in_ready8 : in_ready16;
   endfunction

   function automatic logic get_out_valid(input int w);
      return (w == 8) ? out_valid8 : out_valid16;
   endfunction

   function automatic logic [31:0] get_out(input int w);
      return (w == 8) ? 32'(out8) : out16;
   endfunction

   task automatic drive(input int w, input logic iv, input logic [15:0] av,
                        input logic [15:0] bv, input logic md);
      if (w == 8) begin
         in_valid8 = iv; a8 = av[7:0]; b8 = bv[7:0]; mode8 = md;
      end else begin
         in_valid16 = iv; a16 = av; b16 = bv; mode16 = md;
      end
   endtask

   task automatic set_ready(input int w, input logic v);
      if (w == 8) out_ready8 = v;
      else        out_ready16 = v;
   endtask

   // Reference: full-precision product, truncated to 2*16 bits.
   function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                         input logic m);
      longint p;
      if (m) p = longint'($signed(x)) * longint'($signed(y));
      else   p = longint'(x) * longint'(y);
      return p[31:0];
   endfunction

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'h8000;
         2:       return 16'hFFFF;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // One complete operation: accept, count edges to out_valid, release.
   // With scramble set, inputs (including signed_mode) churn during CALC.
   task automatic do_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic md, input bit scramble,
                        output logic [31:0] prod, output int lat);
      @(negedge clk);
      check("in_ready_idle", 64'(get_in_ready(w)), 64'd1);
      drive(w, 1'b1, av, bv, md);
      @(negedge clk);
      drive(w, 1'b0, av, bv, md);
      lat = 0;
      while (!get_out_valid(w) && lat < 40) begin
         if (scramble)
            drive(w, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), ~md ^ lat[0]);
         @(negedge clk);
         lat++;
      end
      drive(w, 1'b0, av, bv, md);
      check("out_valid_seen", 64'(get_out_valid(w)), 64'd1);
      check("latency", 64'(lat), 64'(w / 2));
      prod = get_out(w);
      set_ready(w, 1'b1);
      @(negedge clk);
      set_ready(w, 1'b0);
      check("out_valid_drop", 64'(get_out_valid(w)), 64'd0);
      check("in_ready_back", 64'(get_in_ready(w)), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] prod;
      int          lat;
      logic [15:0] ra, rb;
      logic        rm;

      vecs[0] = '{8'd200, 8'd150, 1'b0, 16'd30000};
      vecs[1] = '{8'h80,  8'h80,  1'b1, 16'h4000};
      vecs[2] = '{8'hFD,  8'h07,  1'b1, 16'hFFEB};
      vecs[3] = '{8'h00,  8'hFB,  1'b1, 16'h0000};
      vecs[4] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
      vecs[5] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
      vecs[6] = '{8'h7F,  8'h80,  1'b1, 16'hC080};
      vecs[7] = '{8'h80,  8'h80,  1'b0, 16'h4000};
      vecs[8] = '{8'hFF,  8'h7F,  1'b1, 16'hFF81};

      rst_n = 1'b0;
      drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
      drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
      set_ready(8, 1'b0);
      set_ready(16, 1'b0);
      repeat (2) @(negedge clk);
      check("rst_in_ready8",   64'(in_ready8),   64'd1);
      check("rst_out_valid8",  64'(out_valid8),  64'd0);
      check("rst_out8",        64'(out8),        64'd0);
      check("rst_in_ready16",  64'(in_ready16),  64'd1);
      check("rst_out_valid16", 64'(out_valid16), 64'd0);
      check("rst_out16",       64'(out16),       64'd0);
      rst_n = 1'b1;

      // Directed table at WIDTH=8.
      for (int i = 0; i < 9; i++) begin
         do_op(8, 16'(vecs[i].a), 16'(vecs[i].b), vecs[i].mode, 1'b0, prod, lat);
         check($sformatf("vec%0d_product", i), 64'(prod), 64'(vecs[i].exp));
      end

      // Backpressure: product held while out_ready stays low; in_valid ignored.
      @(negedge clk);
      drive(8, 1'b1, 16'd200, 16'd150, 1'b0);
      @(negedge clk);
      drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
      lat = 0;
      while (!out_valid8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("bp_latency", 64'(lat), 64'd4);
      for (int i = 0; i < 10; i++) begin
         check("bp_out_stable", 64'(out8),       64'd30000);
         check("bp_out_valid",  64'(out_valid8), 64'd1);
         check("bp_in_ready",   64'(in_ready8),  64'd0);
         drive(8, 1'(i % 2 == 0), 16'h0011, 16'h0022, 1'b1);
         @(negedge clk);
      end
      drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
      set_ready(8, 1'b1);
      @(negedge clk);
      set_ready(8, 1'b0);
      check("bp_release_valid", 64'(out_valid8), 64'd0);
      check("bp_release_ready", 64'(in_ready8),  64'd1);
      check("bp_out_retained",  64'(out8),       64'd30000);
      do_op(8, 16'd3, 16'd5, 1'b0, 1'b0, prod, lat);
      check("bp_next_product", 64'(prod), 64'd15);

      // Reset during the second CALC cycle discards the operation.
      @(negedge clk);
      drive(8, 1'b1, 16'h0055, 16'h0066, 1'b0);
      @(negedge clk);
      drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_in_ready",  64'(in_ready8),  64'd1);
      check("midrst_out_valid", 64'(out_valid8), 64'd0);
      check("midrst_out",       64'(out8),       64'd0);
      repeat (6) @(negedge clk);
      check("midrst_no_output", 64'(out_valid8), 64'd0);

      // Randomized WIDTH=16 against the arithmetic model.
      for (int i = 0; i < 2000; i++) begin
         ra = pick16();
         rb = pick16();
         rm = 1'($urandom_range(0, 1));
         do_op(16, ra, rb, rm, 1'b1, prod, lat);
         check("rand16_product", 64'(prod), 64'(ref16(ra, rb, rm)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
